// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: pipeline <-> CP0 signal bundle.
//   master : pipeline side (M stage, D-stage NPC logic). Drives the
//            mfc0/mtc0 controls, victim PC/BD/ExcCode, HW interrupts and EXLClr.
//   slave  : CP0 side. Returns Dout, EPCOut and Req.
interface cp0_exc_ctrl_if;
    logic [4:0]  A1;         // mfc0 read register number
    logic [4:0]  A2;         // mtc0 write register number
    logic [31:0] Din;        // mtc0 write data
    logic        We;         // mtc0 write enable
    logic [31:0] VPC;        // victim PC of the M-stage instruction
    logic        BDIn;       // M-stage instruction is in a delay slot
    logic [4:0]  ExcCodeIn;  // M-stage exception code or EXC_NULL
    logic [5:0]  HWInt;      // level-sensitive external interrupts
    logic        EXLClr;     // eret committing in M
    logic [31:0] Dout;       // mfc0 read data
    logic [31:0] EPCOut;     // EPC for the eret NPC path
    logic        Req;        // take-trap request

    modport master (
        output A1, A2, Din, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Dout, EPCOut, Req
    );

    modport slave (
        input  A1, A2, Din, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Dout, EPCOut, Req
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: coprocessor-0 exception responder beside the M stage.
//   Holds SR (12), Cause (13), EPC (14) and a read-only PrID (15).
//   Decides combinationally whether to trap (Req), and on a trapping edge
//   latches EXL, BD, ExcCode and EPC. Serves mfc0 reads and mtc0 writes.
// Ports:
//   Clk    clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    cp0_exc_ctrl_if.slave (A1, A2, Din, We, VPC, BDIn, ExcCodeIn,
//          HWInt, EXLClr in; Dout, EPCOut, Req out)
// Build option:
//   CP0_EPC_FWD_EN  when defined, EPCOut forwards a same-cycle mtc0 EPC write
//                   so eret can follow mtc0 EPC without a stall.
module cp0_exc_ctrl #(
    parameter logic [4:0]  EXC_NULL = 5'd0,
    parameter logic [31:0] PRID_VAL = 32'h2021_0007
) (
    input logic          Clk,
    input logic          Rst_n,
    cp0_exc_ctrl_if.slave bus
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;
    localparam logic [4:0] EXC_INT   = 5'd0;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;   // bits [1:0] are held at 0

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] vpc_adj;
    logic [31:0] din_word;

    always_comb begin
        sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
        cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

        int_req = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
        exc_req = (bus.ExcCodeIn != EXC_NULL) & ~exl_q;
        req     = int_req | exc_req;

        // A delay-slot victim restarts at its branch, one word earlier.
        vpc_adj  = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
        din_word = {bus.Din[31:2], 2'b00};
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = bus.HWInt;

        if (req) begin
            // The trapping instruction does not commit: mtc0 and eret are ignored.
            exl_d      = 1'b1;
            bd_d       = bus.BDIn;
            exc_code_d = int_req ? EXC_INT : bus.ExcCodeIn;
            epc_d      = {vpc_adj[31:2], 2'b00};
        end else begin
            if (bus.We && (bus.A2 == REG_SR)) begin
                im_d  = bus.Din[15:10];
                exl_d = bus.Din[1];
                ie_d  = bus.Din[0];
            end
            if (bus.We && (bus.A2 == REG_EPC)) begin
                epc_d = din_word;
            end
            // Ordered after the SR write so eret wins for EXL only.
            if (bus.EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        case (bus.A1)
            REG_SR:    bus.Dout = sr_val;
            REG_CAUSE: bus.Dout = cause_val;
            REG_EPC:   bus.Dout = epc_q;
            REG_PRID:  bus.Dout = PRID_VAL;
            default:   bus.Dout = 32'd0;
        endcase
    end

`ifdef CP0_EPC_FWD_EN
    assign bus.EPCOut = (bus.We && (bus.A2 == REG_EPC) && !req) ? din_word : epc_q;
`else
    assign bus.EPCOut = epc_q;
`endif

    assign bus.Req = req;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed vector table, a mid-run reset sequence and a
// randomized run checked against a register-level model of CP0.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'h2021_0007;
`ifdef CP0_EPC_FWD_EN
    localparam logic [31:0] EPC_FWD_EXP = 32'h0000_3044;
`else
    localparam logic [31:0] EPC_FWD_EXP = 32'h0000_3020;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        exlclr;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epcout;
    } vec_t;

    vec_t tbl[18];

    // Reference model state: architectural register images.
    logic [31:0] m_sr, m_cause, m_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                         input logic we, input logic [31:0] vpc, input logic bd,
                         input logic [4:0] exc, input logic [5:0] hw, input logic exlclr);
        bus.A1 = a1; bus.A2 = a2; bus.Din = din; bus.We = we; bus.VPC = vpc;
        bus.BDIn = bd; bus.ExcCodeIn = exc; bus.HWInt = hw; bus.EXLClr = exlclr;
    endtask

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                                input logic we, input logic [31:0] vpc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw, input logic exlclr,
                                input logic req, input logic [31:0] dout, input logic [31:0] epcout);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.vpc = vpc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.exlclr = exlclr; v.req = req; v.dout = dout; v.epcout = epcout;
        return v;
    endfunction

    function automatic logic m_int(input logic [5:0] hw);
        logic [31:0] im_bits;
        im_bits = (m_sr >> 10) & 32'h3F;
        return (((32'(hw) & im_bits) != 0) && m_sr[0] && !m_sr[1]);
    endfunction

    function automatic logic m_req(input logic [5:0] hw, input logic [4:0] exc);
        return m_int(hw) || ((exc != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_dout(input logic [4:0] a1);
        if (a1 == 5'd12) return m_sr;
        if (a1 == 5'd13) return m_cause;
        if (a1 == 5'd14) return m_epc;
        if (a1 == 5'd15) return PRID;
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_epcout(input logic we, input logic [4:0] a2,
                                             input logic [31:0] din, input logic req);
`ifdef CP0_EPC_FWD_EN
        if (we && a2 == 5'd14 && !req) return din & 32'hFFFF_FFFC;
`endif
        return m_epc;
    endfunction

    task automatic m_edge(input logic [4:0] a2, input logic [31:0] din, input logic we,
                          input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                          input logic [5:0] hw, input logic exlclr);
        logic       r, i;
        logic [4:0] code;
        r = m_req(hw, exc);
        i = m_int(hw);
        if (r) begin
            code    = i ? 5'd0 : exc;
            m_sr    = m_sr | 32'h2;
            m_cause = (32'(bd) << 31) | (32'(code) << 2);
            m_epc   = (bd ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;
        end else begin
            if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) m_epc = din & 32'hFFFF_FFFC;
            if (exlclr) m_sr = m_sr & ~32'h2;
        end
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
    endtask

    initial begin
        //            a1     a2     din           we    vpc           bd    exc    hw     clr   req   dout          epcout
        tbl[0]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[1]  = mk(5'd15, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, PRID,         32'h0);
        tbl[2]  = mk(5'd12, 5'd12, 32'hFFFF_FC01,1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[3]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h3010,     1'b0, 5'd12, 6'h00, 1'b0, 1'b1, 32'hFC01,     32'h0);
        tbl[4]  = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h3010,     1'b0, 5'd12, 6'h00, 1'b0, 1'b0, 32'h3010,     32'h3010);
        tbl[5]  = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h30,       32'h3010);
        tbl[6]  = mk(5'd12, 5'd12, 32'h401,      1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'hFC01,     32'h3010);
        tbl[7]  = mk(5'd12, 5'd12, 32'h0,        1'b1, 32'h3024,     1'b1, 5'd4,  6'h01, 1'b0, 1'b1, 32'h401,      32'h3010);
        tbl[8]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h403,      32'h3020);
        tbl[9]  = mk(5'd13, 5'd12, 32'h403,      1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h8000_0000,32'h3020);
        tbl[10] = mk(5'd12, 5'd12, 32'h0,        1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h401,      32'h3020);
        tbl[11] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h3F, 1'b0, 1'b0, 32'h8000_0000,32'h3020);
        tbl[12] = mk(5'd13, 5'd12, 32'hFC00,     1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_FC00,32'h3020);
        tbl[13] = mk(5'd12, 5'd12, 32'h2,        1'b1, 32'h0,        1'b0, 5'd0,  6'h3F, 1'b0, 1'b0, 32'hFC00,     32'h3020);
        tbl[14] = mk(5'd12, 5'd14, 32'h3047,     1'b1, 32'h0,        1'b0, 5'd10, 6'h00, 1'b0, 1'b0, 32'h2,        EPC_FWD_EXP);
        tbl[15] = mk(5'd14, 5'd15, 32'hDEAD_BEEF,1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h3044,     32'h3044);
        tbl[16] = mk(5'd15, 5'd13, 32'hFFFF_FFFF,1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, PRID,         32'h3044);
        tbl[17] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0000,32'h3044);

        drive(5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].a1, tbl[k].a2, tbl[k].din, tbl[k].we, tbl[k].vpc, tbl[k].bd,
                  tbl[k].exc, tbl[k].hw, tbl[k].exlclr);
            @(negedge clk);
            chk($sformatf("vec%0d req", k), 32'(bus.Req), 32'(tbl[k].req));
            chk($sformatf("vec%0d dout", k), bus.Dout, tbl[k].dout);
            chk($sformatf("vec%0d epcout", k), bus.EPCOut, tbl[k].epcout);
            @(posedge clk);
            #1;
        end

        // Mid-run asynchronous reset after writing EPC.
        drive(5'd14, 5'd14, 32'h3008, 1'b1, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        @(posedge clk);
        #1;
        drive(5'd14, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
        #1;
        chk("rst pre epc", bus.Dout, 32'h3008);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst epcout", bus.EPCOut, 32'h0);
        chk("rst req", 32'(bus.Req), 32'h0);
        for (int r = 12; r <= 15; r++) begin
            bus.A1 = 5'(r);
            #1;
            chk($sformatf("rst dout a1=%0d", r), bus.Dout, (r == 15) ? PRID : 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized run against the model.
        m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            logic [4:0]  a1, a2, exc;
            logic [31:0] din, vpc;
            logic        we, bd, clr, r;
            logic [5:0]  hw;
            a1  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            a2  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
            din = $urandom;
            we  = ($urandom_range(0, 2) == 0);
            vpc = $urandom;
            bd  = 1'($urandom);
            exc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
            clr = ($urandom_range(0, 7) == 0);
            drive(a1, a2, din, we, vpc, bd, exc, hw, clr);
            r = m_req(hw, exc);
            @(negedge clk);
            chk("rnd req", 32'(bus.Req), 32'(r));
            chk("rnd dout", bus.Dout, m_dout(a1));
            chk("rnd epcout", bus.EPCOut, m_epcout(we, a2, din, r));
            @(posedge clk);
            m_edge(a2, din, we, vpc, bd, exc, hw, clr);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
